keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner: drives one row at a time, synchronises and debounces the column returns, and locks onto the first valid key. It emits one key event per press through a valid/ready handshake. It sits between the keypad pins and the display/digit-shift logic of the lab top level, replacing the purely combinational row/column decoder with a self-contained scan-debounce-event engine.

## Interface
Parameters:
- N_ROWS, 4, number of driven rows (2..8)
- N_COLS, 4, number of sensed columns (2..8)
- SCAN_DIV, 2000, clock cycles each row is driven while scanning (≥4)
- DEBOUNCE_CYC, 50000, consecutive stable cycles required to accept a press or a release (≥2)
- HEX_MAP, 1, 1: key_code is the 4x4 hex legend; 0: key_code is the raw index row*N_COLS+col

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- row_drive  out  N_ROWS  one-hot active-high row strobe
- col_sense  in  N_COLS  raw column returns, active-high, asynchronous to clk
- key_code  out  KW=$clog2(N_ROWS*N_COLS)  code of the pending event, stable while key_valid
- key_valid  out  1  event pending
- key_ready  in  1  consumer accepts the event when key_valid & key_ready
- key_held  out  1  a debounced key is currently held
- overrun  out  1  one-cycle pulse: a press was confirmed while key_valid was still high; that press is dropped

## Operation
- col_sense passes through a 2-flop synchroniser; all logic uses the synchronised value `cs`.
- `cs` is "single" when exactly one bit is set. Zero bits, or two or more bits, are not single.
- FSM states:
  - SCAN: row_idx advances (wraps N_ROWS-1 -> 0) every SCAN_DIV cycles. The sample is taken on the last dwell cycle. If the sample is single, latch row_idx/col_idx, clear the debounce counter, and go to PRESS_DB; otherwise stay in SCAN.
  - PRESS_DB: row held. Each cycle `cs` equals the latched one-hot, the counter increments; on any mismatch, return to SCAN at the next row. When the counter reaches DEBOUNCE_CYC-1, confirm the press and go to HELD.
  - HELD: row held; key_held=1. When `cs` bit col_idx reads 0, clear the counter and go to REL_DB. Additional keys are ignored.
  - REL_DB: the counter increments while bit col_idx reads 0. If the bit reads 1, return to HELD. When the counter reaches DEBOUNCE_CYC-1, go to SCAN starting at row (row_idx+1) mod N_ROWS.
- Press confirm:
  - If key_valid=0: load key_code and set key_valid.
  - If key_valid=1: pulse overrun; key_code is unchanged.
- Handshake:
  - key_valid clears on the cycle after valid&ready.
  - A confirm in the same cycle as the accept loads the new code, keeps key_valid=1, and does not flag overrun.
- No auto-repeat: one event per press-release cycle.
- HEX_MAP=1 requires N_ROWS=N_COLS=4; elaboration fails otherwise.
- Hex legend, row 0..3 by col 0..3:
  - row 0: 1,2,3,A
  - row 1: 4,5,6,B
  - row 2: 7,8,9,C
  - row 3: E,0,F,D
- Counters saturate and never wrap.

## Timing
- Reset values:
  - row_drive = 1 (row 0)
  - key_code = 0, key_valid = 0, key_held = 0, overrun = 0
  - state = SCAN, all counters 0, synchronisers 0
- Reset mid-operation clears everything immediately, including a pending event.
- Press latency: a clean press seen at the synchroniser input reaches key_valid in at most N_ROWS*SCAN_DIV + 2 + DEBOUNCE_CYC + 1 cycles.
- key_held rises in the same cycle as the confirm and falls on REL_DB completion.
- overrun is asserted for exactly one cycle per dropped press.
- All outputs are registered.

## Structure
- Package keypad_pkg:
  - state enum kp_state_t {SCAN, PRESS_DB, HELD, REL_DB}
  - function hex_of(row, col) returning logic [3:0] with the legend above
  - localparam defaults
- Sub-module sync2 (parametrised-width 2-flop synchroniser), instantiated once for col_sense.

## Test plan
- Reset, no keys: row_drive cycles 0001→0010→0100→1000→0001, each row lasting SCAN_DIV cycles; key_valid stays 0.
- Press row1/col2 clean (DEBOUNCE_CYC=8, SCAN_DIV=4), key_ready=1 -> one key_valid pulse with key_code=6, key_held=1 until release debounce completes, and no second event.
- Press row3/col1 with 3-cycle bounce glitches inside the debounce window -> debounce restarts; a single event with key_code=0 once stable for 8 cycles.
- key_ready=0, press 5 then 9 -> key_code stays 5, one overrun pulse at the confirm of 9; after key_ready=1, key_valid drops the next cycle.
- Two columns active in the same row -> no event; scanning continues.
- Assert reset while in HELD with key_valid=1 -> all outputs return to reset values at once; after deassertion, scanning restarts from row 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type, default parameters and the 4x4 hex legend.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} kp_state_t;
  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;
  localparam int DEF_SCAN_DIV = 2000;
  localparam int DEF_DEBOUNCE = 50000;
  localparam int DEF_HEX_MAP = 1;
  localparam logic [3:0] HEX_LUT [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  function automatic logic [3:0] hex_of(input logic [2:0] row, input logic [2:0] col);
    return (row < 3'd4 && col < 3'd4) ? HEX_LUT[{row[1:0], col[1:0]}] : 4'h0;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: parametrised-width two-flop synchroniser with async active-low reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobe scanner with debounced press/release and a one-deep
// valid/ready key event output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int N_ROWS = DEF_ROWS,
  parameter int N_COLS = DEF_COLS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE,
  parameter int HEX_MAP = DEF_HEX_MAP,
  localparam int KW = $clog2(N_ROWS * N_COLS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [N_ROWS-1:0] row_drive,
  input  logic [N_COLS-1:0] col_sense,
  output logic [KW-1:0]     key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              overrun
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  if (HEX_MAP != 0 && (N_ROWS != 4 || N_COLS != 4)) begin : g_bad_map
    $error("HEX_MAP=1 requires a 4x4 keypad");
  end
  logic [N_COLS-1:0] cs, col_mask;
  kp_state_t state;
  logic [2:0] row_idx, col_idx, next_row, cs_col;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic single, col_on, match, accept, confirm;
  logic [KW-1:0] code;
  sync2 #(.W(N_COLS)) u_sync (.clk(clk), .reset(reset), .d(col_sense), .q(cs));
  always_comb begin
    cs_col = '0;
    for (int i = 0; i < N_COLS; i++) if (cs[i]) cs_col = 3'(i);
    single = cs != '0 && (cs & (cs - 1'b1)) == '0;
    col_mask = N_COLS'(1) << col_idx;
    match = cs == col_mask;
    col_on = |(cs & col_mask);
    next_row = (row_idx == 3'(N_ROWS - 1)) ? 3'd0 : row_idx + 3'd1;
    accept = key_valid & key_ready;
    confirm = state == PRESS_DB && match && cnt == CW'(DEBOUNCE_CYC - 1);
    code = HEX_MAP != 0 ? KW'(hex_of(row_idx, col_idx)) : KW'(row_idx * N_COLS + 32'(col_idx));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= SCAN;
      row_idx <= '0;
      col_idx <= '0;
      div <= '0;
      cnt <= '0;
      row_drive <= N_ROWS'(1);
      key_code <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // an accept in the confirm cycle frees the slot, so the new press is kept
      if (confirm) begin
        if (!key_valid || accept) begin
          key_code <= code;
          key_valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (accept) key_valid <= 1'b0;
      case (state)
        SCAN:
          if (div == DW'(SCAN_DIV - 1)) begin
            div <= '0;
            if (single) begin
              col_idx <= cs_col;
              cnt <= '0;
              state <= PRESS_DB;
            end else begin
              row_idx <= next_row;
              row_drive <= N_ROWS'(1) << next_row;
            end
          end else div <= div + 1'b1;
        PRESS_DB:
          if (!match) begin
            row_idx <= next_row;
            row_drive <= N_ROWS'(1) << next_row;
            state <= SCAN;
          end else if (confirm) begin
            state <= HELD;
            key_held <= 1'b1;
          end else cnt <= cnt + 1'b1;
        HELD:
          if (!col_on) begin
            cnt <= '0;
            state <= REL_DB;
          end
        REL_DB:
          if (col_on) state <= HELD;
          else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            state <= SCAN;
            key_held <= 1'b0;
            row_idx <= next_row;
            row_drive <= N_ROWS'(1) << next_row;
          end else cnt <= cnt + 1'b1;
        default: state <= SCAN;
      endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driving col_sense from row_drive, checked
// every cycle against a behavioural scan/debounce model.
module tb_keypad_scanner;
  localparam int NR = 4, NC = 4, SD = 4, DB = 8;
  localparam int LAT = NR * SD + 2 + DB + 1;
  logic clk = 0, reset = 0, key_ready = 1;
  logic [NR-1:0] row_drive;
  logic [NC-1:0] col_sense;
  logic [3:0] key_code;
  logic key_valid, key_held, overrun;
  logic [NR*NC-1:0] keys = '0;
  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;
  int events = 0, ovr_seen = 0;
  logic [3:0] last_code = '0;
  int legend [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  // model: mode 0 scanning, 1 press settling, 2 held, 3 release settling
  int m_row, m_age, m_mode, m_run, m_lrow, m_lcol;
  logic m_valid, m_held, m_ovr;
  logic [3:0] m_code;
  logic [NC-1:0] m_s1, m_s2;

  always #5 clk = ~clk;

  keypad_scanner #(.N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE_CYC(DB), .HEX_MAP(1)) dut (
    .clk(clk), .reset(reset), .row_drive(row_drive), .col_sense(col_sense),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overrun(overrun)
  );

  always_comb begin
    col_sense = '0;
    for (int r = 0; r < NR; r++) if (row_drive[r]) col_sense |= keys[r*NC +: NC];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_reset;
    m_row = 0; m_age = 0; m_mode = 0; m_run = 0; m_lrow = 0; m_lcol = 0;
    m_valid = 0; m_held = 0; m_ovr = 0; m_code = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic m_step;
    logic [NC-1:0] cs;
    bit confirm, acc;
    cs = m_s2;
    confirm = 0;
    acc = m_valid && key_ready;
    m_ovr = 0;
    case (m_mode)
      0: begin
        m_age++;
        if (m_age == SD) begin
          m_age = 0;
          if ($countones(cs) == 1) begin
            m_lrow = m_row; m_lcol = $clog2(cs); m_run = 0; m_mode = 1;
          end else m_row = (m_row + 1) % NR;
        end
      end
      1: if (cs == NC'(1) << m_lcol) begin
        m_run++;
        if (m_run == DB) begin confirm = 1; m_mode = 2; m_held = 1; end
      end else begin
        m_mode = 0; m_row = (m_row + 1) % NR;
      end
      2: if (!cs[m_lcol]) begin m_mode = 3; m_run = 0; end
      default: if (cs[m_lcol]) m_mode = 2;
      else begin
        m_run++;
        if (m_run == DB) begin m_mode = 0; m_held = 0; m_row = (m_row + 1) % NR; end
      end
    endcase
    if (confirm) begin
      if (!m_valid || acc) begin m_code = 4'(legend[m_lrow][m_lcol]); m_valid = 1; end
      else m_ovr = 1;
    end else if (acc) m_valid = 0;
    m_s2 = m_s1;
    m_s1 = col_sense;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (!reset) m_reset();
      check("outputs", {row_drive, key_valid, key_valid ? key_code : 4'h0, key_held, overrun},
            {4'(1 << m_row), m_valid, m_valid ? m_code : 4'h0, m_held, m_ovr});
      if (key_valid && key_ready && reset) begin events++; last_code = key_code; end
      if (overrun) ovr_seen++;
      if (reset) m_step();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int ev0, ov0, t;
    m_reset();
    @(posedge clk); #1;
    chk_en = 1;
    cyc(2);
    check("reset_row", row_drive, 1);
    check("reset_valid", key_valid, 0);
    reset = 1;
    for (int k = 1; k <= 2 * NR * SD; k++) begin
      cyc(1);
      check("scan_seq", row_drive, 1 << ((k / SD) % NR));
    end
    check("idle_valid", key_valid, 0);
    // clean press of '6'
    ev0 = events;
    keys[1*NC+2] = 1;
    t = 0;
    while (!key_valid && t < LAT + 2) begin cyc(1); t++; end
    check("press_latency", key_valid, 1);
    check("code_6", key_code, 4'h6);
    check("held_6", key_held, 1);
    cyc(20);
    keys = '0;
    cyc(40);
    check("events_6", events - ev0, 1);
    check("last_6", last_code, 4'h6);
    check("released_6", key_held, 0);
    // bouncing press of '0'
    ev0 = events;
    keys[3*NC+1] = 1; cyc(20);
    keys = '0; cyc(3);
    keys[3*NC+1] = 1; cyc(5);
    keys = '0; cyc(3);
    keys[3*NC+1] = 1; cyc(80);
    keys = '0; cyc(40);
    check("events_0", events - ev0, 1);
    check("last_0", last_code, 4'h0);
    // overrun: 5 pending, then 9 dropped
    key_ready = 0;
    ov0 = ovr_seen;
    keys[1*NC+1] = 1; cyc(60);
    keys = '0; cyc(40);
    check("pend_valid", key_valid, 1);
    check("pend_5", key_code, 4'h5);
    keys[2*NC+2] = 1; cyc(60);
    check("keep_5", key_code, 4'h5);
    check("overrun_cnt", ovr_seen - ov0, 1);
    keys = '0; cyc(40);
    key_ready = 1;
    cyc(1);
    check("accept_drop", key_valid, 0);
    // two columns in one row: ignored
    ev0 = events;
    keys[2*NC+0] = 1; keys[2*NC+3] = 1; cyc(80);
    check("multi_events", events - ev0, 0);
    check("multi_valid", key_valid, 0);
    check("multi_held", key_held, 0);
    keys = '0; cyc(20);
    // reset while held with an event pending
    key_ready = 0;
    keys[0] = 1; cyc(60);
    check("pre_rst_held", key_held, 1);
    check("pre_rst_valid", key_valid, 1);
    reset = 0; #1;
    check("rst_row", row_drive, 1);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_code", key_code, 0);
    keys = '0; key_ready = 1;
    cyc(2);
    reset = 1;
    cyc(1);
    check("restart_row", row_drive, 1);
    // random phase, checked cycle by cycle against the model
    repeat (60) begin
      int sel;
      keys = '0;
      sel = $urandom_range(0, 3);
      if (sel != 0) keys[$urandom_range(0, NR*NC-1)] = 1;
      if (sel == 3) keys[$urandom_range(0, NR*NC-1)] = 1;
      key_ready = $urandom_range(0, 3) != 0;
      cyc($urandom_range(3, 70));
    end
    keys = '0; key_ready = 1;
    cyc(60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
